// File: rtl/dmem_arbiter.sv
// dmem_arbiter: serialises CPU load/store and UART-loader accesses onto the single data memory port.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise the loader always wins a tie.
module dmem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

  state_t            state_q, state_d;
  logic              win_ldr_q, win_ldr_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              ldr_rvalid_q, ldr_rvalid_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;
  logic              pick_ldr;
  logic [ADDR_W-1:0] sel_addr;

`ifdef DMEM_ARB_RR_EN
  // Pointer names the port favoured on a tie; it flips away from whoever was just granted.
  logic rr_ldr_q, rr_ldr_d;

  always_comb begin
    pick_ldr = ldr_req & (~cpu_req | rr_ldr_q);
    rr_ldr_d = rr_ldr_q;
    if (state_q == ISSUE) rr_ldr_d = ~win_ldr_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) rr_ldr_q <= 1'b0;
    else        rr_ldr_q <= rr_ldr_d;
  end
`else
  always_comb pick_ldr = ldr_req;
`endif

  assign sel_addr = pick_ldr ? ldr_addr : cpu_addr;

  always_comb begin
    state_d      = state_q;
    win_ldr_d    = win_ldr_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_rvalid_d = 1'b0;
    ldr_rvalid_d = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    ldr_rdata_d  = ldr_rdata_q;
    case (state_q)
      IDLE: begin
        if (cpu_req || ldr_req) begin
          win_ldr_d   = pick_ldr;
          mem_we_d    = pick_ldr ? ldr_we : cpu_we;
          mem_addr_d  = sel_addr & ~ADDR_W'(3);
          mem_wdata_d = pick_ldr ? ldr_wdata : cpu_wdata;
          state_d     = ISSUE;
        end else begin
          mem_we_d = 1'b0;
        end
      end
      ISSUE: begin
        // mem_we_q still holds the recorded op while memory samples the command
        mem_we_d = 1'b0;
        state_d  = mem_we_q ? IDLE : WAIT_RD;
      end
      WAIT_RD: begin
        if (win_ldr_q) begin
          ldr_rdata_d  = mem_rdata;
          ldr_rvalid_d = 1'b1;
        end else begin
          cpu_rdata_d  = mem_rdata;
          cpu_rvalid_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      win_ldr_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      ldr_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      ldr_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      win_ldr_q    <= win_ldr_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      ldr_rvalid_q <= ldr_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ldr_rdata_q  <= ldr_rdata_d;
    end
  end

  assign cpu_gnt    = (state_q == ISSUE) & ~win_ldr_q;
  assign ldr_gnt    = (state_q == ISSUE) &  win_ldr_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign ldr_rvalid = ldr_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign ldr_rdata  = ldr_rdata_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_stall  = cpu_req & ~(cpu_gnt & cpu_we) & ~cpu_rvalid;
endmodule
